// File: rtl/l0_xfer_pkg.sv
// rtl/l0_xfer_pkg.sv - shared status codes and channel state type for the L0 transfer counter
package l0_xfer_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_COMP = 2'b10;
  localparam logic [1:0] ST_WB   = 2'b11;

  typedef enum logic [1:0] {
    CH_IDLE = 2'b00,
    CH_RUN  = 2'b01,
    CH_DONE = 2'b10
  } chan_state_t;

endpackage

// File: rtl/l0_xfer_chan.sv
// rtl/l0_xfer_chan.sv - one channel: IDLE/RUN/DONE FSM with saturating transfer cycle counter
module l0_xfer_chan
  import l0_xfer_pkg::*;
#(
  parameter int CNT_W  = 11,
  parameter int TARGET = 102
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       status,
  input  logic             stall,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             done_pulse,
  output logic             abort_pulse,
  output logic             phase
);

  localparam logic [CNT_W-1:0] TGT     = CNT_W'(TARGET);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             phase_q, phase_d;
  logic             done_p_q, done_p_d;
  logic             abort_p_q, abort_p_d;
  logic             active, same_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CH_IDLE;
      count_q   <= '0;
      phase_q   <= 1'b0;
      done_p_q  <= 1'b0;
      abort_p_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      done_p_q  <= done_p_d;
      abort_p_q <= abort_p_d;
    end
  end

  // The latched code is always active, so phase alone reconstructs it as {phase, 1}.
  always_comb begin
    active    = (status == ST_LOAD) || (status == ST_WB);
    same_code = (status == {phase_q, 1'b1});
    count_inc = count_q + CNT_ONE;
    state_d   = state_q;
    count_d   = count_q;
    phase_d   = phase_q;
    done_p_d  = 1'b0;
    abort_p_d = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (active && !stall) begin
          count_d  = CNT_ONE;
          phase_d  = status[1];
          state_d  = (TGT == CNT_ONE) ? CH_DONE : CH_RUN;
          done_p_d = (TGT == CNT_ONE);
        end
      end
      CH_RUN: begin
        if (!stall) begin
          if (same_code) begin
            count_d = count_inc;
            if (count_inc == TGT) begin
              state_d  = CH_DONE;
              done_p_d = 1'b1;
            end
          end else if (active) begin
            // Load <-> write-back switch restarts the transfer in the same cycle.
            abort_p_d = 1'b1;
            count_d   = CNT_ONE;
            phase_d   = status[1];
            state_d   = (TGT == CNT_ONE) ? CH_DONE : CH_RUN;
            done_p_d  = (TGT == CNT_ONE);
          end else begin
            abort_p_d = 1'b1;
            count_d   = '0;
            state_d   = CH_IDLE;
          end
        end
      end
      CH_DONE: begin
        if (!same_code) begin
          count_d = '0;
          state_d = CH_IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = CH_IDLE;
      end
    endcase
  end

  always_comb begin
    count       = count_q;
    busy        = (state_q == CH_RUN);
    done        = (state_q == CH_DONE);
    done_pulse  = done_p_q;
    abort_pulse = abort_p_q;
    phase       = phase_q;
  end

endmodule

// File: rtl/l0_mem_transfer_counter.sv
// rtl/l0_mem_transfer_counter.sv - per-channel L0 memory transfer counters; optional stall input under L0_XFER_STALL_EN
module l0_mem_transfer_counter #(
  parameter int                      NUM_CH         = 3,
  parameter int                      CNT_W          = 11,
  parameter int                      START_OVERHEAD = 100,
  parameter logic [NUM_CH*CNT_W-1:0] CH_ITEMS       = {11'd8, 11'd8, 11'd2}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*NUM_CH-1:0]       ch_status,
`ifdef L0_XFER_STALL_EN
  input  logic [NUM_CH-1:0]         ch_stall,
`endif
  output logic [NUM_CH*CNT_W-1:0]   ch_count,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_done_pulse,
  output logic [NUM_CH-1:0]         ch_abort_pulse,
  output logic [NUM_CH-1:0]         ch_phase
);

  logic [NUM_CH-1:0] stall_vec;

`ifdef L0_XFER_STALL_EN
  assign stall_vec = ch_stall;
`else
  assign stall_vec = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int TGT = START_OVERHEAD + int'(CH_ITEMS[c*CNT_W +: CNT_W]);

    if (TGT < 1 || TGT > (2**CNT_W) - 1) begin : g_bad_target
      $error("l0_mem_transfer_counter: channel target out of range for counter width");
    end

    l0_xfer_chan #(
      .CNT_W  (CNT_W),
      .TARGET (TGT)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .status      (ch_status[2*c +: 2]),
      .stall       (stall_vec[c]),
      .count       (ch_count[c*CNT_W +: CNT_W]),
      .busy        (ch_busy[c]),
      .done        (ch_done[c]),
      .done_pulse  (ch_done_pulse[c]),
      .abort_pulse (ch_abort_pulse[c]),
      .phase       (ch_phase[c])
    );
  end

endmodule

// File: doc/l0_mem_transfer_counter.md
L0_MEM_TRANSFER_COUNTER -- requirements
Module: l0_mem_transfer_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning the number of independent L0 buffer channels (channel 0 weight, 1 input, 2 output).
REQ-002 SHALL have parameter CNT_W, default 11, meaning the counter width.
REQ-003 SHALL have parameter START_OVERHEAD, default 100, meaning the fixed memory start-up cycles per transfer.
REQ-004 SHALL have parameter CH_ITEMS, a packed NUM_CH*CNT_W vector, default {8,8,2} (ch2..ch0), meaning the data items per channel; per-channel TARGET[c] = START_OVERHEAD + CH_ITEMS[c].
REQ-005 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port ch_status, input, 2*NUM_CH bits: per-channel status; 2'b00 idle, 2'b01 load from mem, 2'b10 compute, 2'b11 write-back to mem.
REQ-008 SHALL have port ch_stall, input, NUM_CH bits: per-channel memory stall; present only under L0_XFER_STALL_EN.
REQ-009 SHALL have port ch_count, output, NUM_CH*CNT_W bits: per-channel elapsed transfer cycles.
REQ-010 SHALL have port ch_busy, output, NUM_CH bits: channel in RUN.
REQ-011 SHALL have port ch_done, output, NUM_CH bits: level, channel in DONE.
REQ-012 SHALL have port ch_done_pulse, output, NUM_CH bits: one-cycle pulse on entry to DONE.
REQ-013 SHALL have port ch_abort_pulse, output, NUM_CH bits: one-cycle pulse when RUN is left before TARGET.
REQ-014 SHALL have port ch_phase, output, NUM_CH bits: 0 load, 1 write-back; captured on entry to RUN.

Function
REQ-015 SHALL run one FSM per channel with states IDLE, RUN, DONE; active code = 01 (load) or 11 (write-back).
REQ-016 IDLE: on an active code the FSM SHALL go to RUN, set count to 1 and latch the phase; if TARGET==1 it SHALL go directly to DONE with ch_done_pulse.
REQ-017 RUN: while status equals the latched code, count SHALL increment by 1 per cycle; the cycle count reaches TARGET the FSM SHALL enter DONE with ch_done_pulse high for exactly that cycle.
REQ-018 RUN: a status of 00 or 10 SHALL assert ch_abort_pulse for one cycle, clear count to 0 and return to IDLE.
REQ-019 RUN: a direct switch between 01 and 11 SHALL assert ch_abort_pulse, restart with count 1 and latch the new phase in the same cycle.
REQ-020 DONE: count SHALL hold at TARGET (saturate, no wrap); when status leaves the latched code the FSM SHALL return to IDLE and clear count to 0 one cycle later.
REQ-021 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-022 Elaboration SHALL fail if any TARGET[c] > 2**CNT_W-1 or TARGET[c] == 0.

Reset
REQ-023 rst_n low SHALL immediately force all FSMs to IDLE and all outputs to 0, including mid-transfer; counting SHALL resume only on the first rising clk after rst_n is released.

Configuration
REQ-024 With L0_XFER_STALL_EN defined, ch_stall[c] high SHALL freeze count in RUN (no increment, no abort) and block IDLE->RUN entry; without it, the port SHALL be absent and behaviour SHALL equal ch_stall tied to 0.

Structure
REQ-025 A shared package l0_xfer_pkg SHALL hold the status codes (ST_IDLE, ST_LOAD, ST_COMP, ST_WB) and the channel state enum.
REQ-026 The per-channel FSM and counter SHALL be one sub-module, l0_xfer_chan, instantiated NUM_CH times by generate.

Verification
REQ-027 Ch0 status 01 held for 110 cycles with default params -> ch_count[0] reaches 102 on cycle 102, ch_done_pulse[0] high for exactly that cycle, count then holds at 102.
REQ-028 Ch1 status 01 for 50 cycles then 10 -> ch_abort_pulse[1] single cycle, count 0, FSM in IDLE; ch0/ch2 unaffected.
REQ-029 Ch2 status 01 for 20 cycles then 11 -> abort pulse, count restarts at 1, ch_phase[2]=1, done at 108 cycles of 11.
REQ-030 rst_n asserted mid-RUN at count 57, asynchronous to clk -> all outputs 0 without waiting for a clock edge; after release, status 01 restarts count from 1.
REQ-031 With L0_XFER_STALL_EN: ch0 load with ch_stall[0] high for 10 cycles mid-run -> done after 112 cycles, no abort pulse.
